bcd_conv_ctrl: RTL and testbench
================================

Name: bcd_conv_ctrl

Overview:
Controller and arbiter that shares the single result-to-BCD converter between two requesters: the ALU result path (req0) and the operand-entry echo path (req1).
- Accepts a binary value with format flags from the granted requester.
- Starts the converter and waits for its done.
- Captures the 60-bit BCD result and presents it to the display driver with a valid/ready handshake.
- Pulses the converter's reset between conversions, since the converter needs a reset before every new job.
- Flags a sticky error if the converter never completes.

Parameters:
M, 24, width of binary value to convert
BCD_WIDTH, 60, width of converter BCD output (15 digits)
TIMEOUT, 255, max cycles to wait for conv_done before abort

Ports:
CLK  in  1  system clock
RST  in  1  reset; one clock; reset is asynchronous and active-high
req0_valid  in  1  ALU result request
req0_val  in  M  value to convert
req0_fixed  in  1  value is fixed-point
req0_signed  in  1  value is two's-complement
req0_ready  out  1  one-cycle accept strobe for req0
req1_valid  in  1  echo-path request
req1_val  in  M  value to convert
req1_fixed  in  1  value is fixed-point
req1_signed  in  1  value is two's-complement
req1_ready  out  1  one-cycle accept strobe for req1
conv_ce  out  1  converter start, one-cycle pulse
conv_val  out  M  converter input value, held stable through conversion
conv_fixed  out  1  converter fixed-point flag
conv_signed  out  1  converter signed flag
conv_rst  out  1  converter reset
conv_done  in  1  converter done (level)
conv_bcd  in  BCD_WIDTH  converter BCD result
out_valid  out  1  BCD result available
out_bcd  out  BCD_WIDTH  captured BCD result
out_src  out  1  0 = req0, 1 = req1
out_ready  in  1  display driver consumes result
err_clr  in  1  clears sticky error
error_led  out  1  sticky timeout error

Behaviour:
- Reset values:
  - state = IDLE.
  - All ready, conv_ce, out_valid and error_led = 0.
  - out_bcd, conv_val, conv_fixed, conv_signed and out_src = 0.
  - Round-robin pointer = 1, so req0 wins the first tie.
  - conv_rst = RST OR (state == CLEAR). The converter is therefore held in reset during system reset, and a reset mid-operation aborts the conversion.
- States: IDLE, ISSUE, WAIT, CLEAR, HOLD.
- IDLE:
  - If any valid is high, grant one requester; on a tie, grant the one not granted last.
  - Drive reqN_ready = 1 combinationally in this cycle only.
  - Register val/fixed/signed into the conv_* outputs and record the grant in out_src.
  - Next state: ISSUE.
  - A requester must hold its valid and data until it sees ready.
- ISSUE: conv_ce = 1 for exactly one cycle; clear the timeout counter; next state WAIT.
- WAIT:
  - Counter increments every cycle.
  - If conv_done = 1: out_bcd <= conv_bcd; set the got_result flag; next state CLEAR.
  - Else if counter == TIMEOUT-1: error_led <= 1; got_result = 0; out_bcd unchanged; next state CLEAR.
  - If conv_done and timeout coincide, conv_done wins.
- CLEAR: conv_rst = 1 for one cycle. Next state HOLD if got_result, else IDLE. Update the round-robin pointer to the last grant here.
- HOLD:
  - out_valid = 1, with out_bcd and out_src stable.
  - On out_ready = 1: out_valid drops the next cycle; next state IDLE.
  - No new grant is made while in HOLD.
- Latency:
  - Accept at cycle t; conv_ce at t+1.
  - conv_done sampled at cycle d; conv_rst at d+1; out_valid from d+2.
  - Minimum accept-to-accept spacing is 5 cycles plus the conversion time plus the out_ready wait.
- error_led:
  - Sticky; cleared only by err_clr or RST.
  - If err_clr coincides with a new timeout, the set wins.
- conv_val, conv_fixed and conv_signed change only in the IDLE accept cycle.

Decomposition:
- State encodings (3-bit), the SRC_ALU / SRC_ECHO constants and the TIMEOUT default go in the shared define.v alongside the existing opcode and state macros.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter with a pointer-update input and a one-hot grant output.

Test Plan:
1. req0 only, val = 24'd123456, unsigned integer; converter model done after 30 cycles → conv_ce one pulse, conv_val = 123456; out_valid with out_bcd = model output, out_src = 0; conv_rst pulse one cycle before out_valid.
2. req0 and req1 valid in the same cycle after reset → req0 granted first, then req1; repeated tie afterwards → alternates 0, 1, 0, 1.
3. req1 val = -24'sd128, signed = 1; out_ready held low for 10 cycles → out_valid held, out_bcd stable; no conv_ce until out_ready is seen.
4. Converter model never asserts done → error_led = 1 exactly TIMEOUT cycles after conv_ce; conv_rst pulses; no out_valid; state returns to IDLE; err_clr clears error_led.
5. conv_done asserted in the cycle the counter reaches TIMEOUT-1 → result captured, error_led stays 0.
6. RST asserted during WAIT → all outputs at reset values immediately (asynchronously), conv_rst high; after release, a pending req0 is accepted normally.

Source files
------------

// File: rtl/bcd_conv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bcd_conv_ctrl_pkg
// Shared definitions for the BCD converter controller slice.
//   - default widths and the conversion timeout
//   - requester source codes reported on out_src
//   - controller state encoding (3-bit)
//   - small helper to turn a source code into a one-hot grant vector
// ---------------------------------------------------------------------------
package bcd_conv_ctrl_pkg;

    localparam int M_DEFAULT         = 24;
    localparam int BCD_WIDTH_DEFAULT = 60;
    localparam int TIMEOUT_DEFAULT   = 255;

    // Source codes: ALU result path is requester 0, operand echo is requester 1
    localparam logic SRC_ALU  = 1'b0;
    localparam logic SRC_ECHO = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    function automatic logic [1:0] src_to_onehot(input logic src);
        return (src == SRC_ECHO) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bcd_conv_ctrl_if.sv
// ---------------------------------------------------------------------------
// Interfaces for the BCD converter controller.
//   bcd_req_if  : requester -> controller (valid/val/fixed/is_signed, ready back)
//                 master = requester, slave = controller
//   bcd_conv_if : controller -> converter (ce/val/fixed/is_signed/rst, done/bcd back)
//                 master = controller, slave = converter
//   bcd_out_if  : controller -> display driver (valid/bcd/src, ready back)
//                 master = controller, slave = display driver
// ---------------------------------------------------------------------------
interface bcd_req_if
    import bcd_conv_ctrl_pkg::*;
#(
    parameter int M = M_DEFAULT
) ();
    logic         valid;
    logic [M-1:0] val;
    logic         fixed;
    logic         is_signed;
    logic         ready;

    modport master (output valid, val, fixed, is_signed, input  ready);
    modport slave  (input  valid, val, fixed, is_signed, output ready);
endinterface

interface bcd_conv_if
    import bcd_conv_ctrl_pkg::*;
#(
    parameter int M         = M_DEFAULT,
    parameter int BCD_WIDTH = BCD_WIDTH_DEFAULT
) ();
    logic                 ce;
    logic [M-1:0]         val;
    logic                 fixed;
    logic                 is_signed;
    logic                 rst;
    logic                 done;
    logic [BCD_WIDTH-1:0] bcd;

    modport master (output ce, val, fixed, is_signed, rst, input  done, bcd);
    modport slave  (input  ce, val, fixed, is_signed, rst, output done, bcd);
endinterface

interface bcd_out_if
    import bcd_conv_ctrl_pkg::*;
#(
    parameter int BCD_WIDTH = BCD_WIDTH_DEFAULT
) ();
    logic                 valid;
    logic [BCD_WIDTH-1:0] bcd;
    logic                 src;
    logic                 ready;

    modport master (output valid, bcd, src, input  ready);
    modport slave  (input  valid, bcd, src, output ready);
endinterface

// File: rtl/bcd_conv_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. The pointer remembers the most recent grant and
// only moves when the owner tells it to (update), so a grant that is still
// being serviced does not disturb the fairness order.
//   clk, rst     : clock, async active-high reset (pointer resets to 1 so
//                  requester 0 wins the first tie)
//   req[1:0]     : request vector
//   update       : load the pointer from update_grant this cycle
//   update_grant : one-hot grant to record as "last served"
//   grant[1:0]   : one-hot grant, combinational from req and pointer
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic [1:0] update_grant,
    output logic [1:0] grant
);

    logic last_q;

    // Pointer holds the index of the last requester served; an all-zero
    // update vector is ignored rather than treated as requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update && (update_grant != 2'b00)) begin
            last_q <= update_grant[1];
        end
    end

    // A lone request is granted directly; on a tie the requester that was
    // not served last wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/bcd_conv_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_conv_ctrl
// Shares one binary-to-BCD converter between the ALU result path (req0) and
// the operand echo path (req1). A granted job is latched onto the converter
// inputs, started with a one-cycle conv_ce, and the result is captured when
// conv_done rises. The converter is reset for one cycle after every job, and
// the captured result is then offered to the display driver until consumed.
// A job that never completes raises a sticky error_led.
//   clk, rst  : clock, async active-high reset
//   req0/req1 : requester channels (slave side), ready is a one-cycle accept
//   conv      : converter channel (master side)
//   out       : result channel to the display driver (master side)
//   err_clr   : clears error_led
//   error_led : sticky conversion-timeout flag
// ---------------------------------------------------------------------------
module bcd_conv_ctrl
    import bcd_conv_ctrl_pkg::*;
#(
    parameter int M         = M_DEFAULT,
    parameter int BCD_WIDTH = BCD_WIDTH_DEFAULT,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    bcd_req_if.slave   req0,
    bcd_req_if.slave   req1,
    bcd_conv_if.master conv,
    bcd_out_if.master  out,
    input  logic       err_clr,
    output logic       error_led
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 got_result_q;
    logic [M-1:0]         conv_val_q;
    logic                 conv_fixed_q;
    logic                 conv_signed_q;
    logic                 out_src_q;
    logic [BCD_WIDTH-1:0] out_bcd_q;
    logic                 error_q;
    logic [1:0]           arb_req;
    logic [1:0]           grant;
    logic                 timeout_hit;

    // Requests only reach the arbiter while idle, so nothing is granted
    // during a conversion or while a result waits for the display.
    assign arb_req = (state_q == ST_IDLE) ? {req1.valid, req0.valid} : 2'b00;

    rr_arb2 u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (arb_req),
        .update       (state_q == ST_CLEAR),
        .update_grant (src_to_onehot(out_src_q)),
        .grant        (grant)
    );

    // Ready is masked during reset so a held request is not strobed while
    // the registers cannot take it.
    assign req0.ready = grant[0] & ~rst;
    assign req1.ready = grant[1] & ~rst;

    // Timeout fires on the last allowed wait cycle only if done is absent,
    // which lets a coincident conv_done win.
    assign timeout_hit = (state_q == ST_WAIT) && !conv.done && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept -> start -> wait for done or timeout ->
    // converter reset -> hold result (only if one was captured).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (conv.done || (cnt_q == CNT_LAST)) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = got_result_q ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (out.ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: job latch on accept, wait counter, result capture.
    // The converter inputs only change in the accept cycle, so they stay
    // stable for the whole conversion and the following hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_val_q    <= '0;
            conv_fixed_q  <= 1'b0;
            conv_signed_q <= 1'b0;
            out_src_q     <= SRC_ALU;
            out_bcd_q     <= '0;
            cnt_q         <= '0;
            got_result_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant[1]) begin
                        conv_val_q    <= req1.val;
                        conv_fixed_q  <= req1.fixed;
                        conv_signed_q <= req1.is_signed;
                        out_src_q     <= SRC_ECHO;
                    end else if (grant[0]) begin
                        conv_val_q    <= req0.val;
                        conv_fixed_q  <= req0.fixed;
                        conv_signed_q <= req0.is_signed;
                        out_src_q     <= SRC_ALU;
                    end
                end
                ST_ISSUE: begin
                    cnt_q        <= '0;
                    got_result_q <= 1'b0;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (conv.done) begin
                        out_bcd_q    <= conv.bcd;
                        got_result_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky error: a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (timeout_hit) begin
            error_q <= 1'b1;
        end else if (err_clr) begin
            error_q <= 1'b0;
        end
    end

    // The converter is held in reset with the system and pulsed after each
    // job because it must be reset before it can accept the next one.
    assign conv.ce        = (state_q == ST_ISSUE);
    assign conv.rst       = rst | (state_q == ST_CLEAR);
    assign conv.val       = conv_val_q;
    assign conv.fixed     = conv_fixed_q;
    assign conv.is_signed = conv_signed_q;

    assign out.valid = (state_q == ST_HOLD);
    assign out.bcd   = out_bcd_q;
    assign out.src   = out_src_q;

    assign error_led = error_q;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_ctrl
// Scoreboard bench for bcd_conv_ctrl. Stimulus records each accepted job;
// a converter model starts it on conv_ce, picks a latency and pushes the
// expected display result (computed from the requested value, not from the
// DUT) into a queue; a monitor pops and compares whenever the display
// driver consumes a result, and checks handshake timing around it.
// ---------------------------------------------------------------------------
module tb_bcd_conv_ctrl;

    localparam int M  = 24;
    localparam int BW = 60;
    localparam int TO = 255;

    typedef struct {
        bit          src;
        logic [23:0] val;
        bit          fx;
        bit          sg;
    } job_t;

    typedef struct {
        logic [59:0] bcd;
        bit          src;
    } res_t;

    logic clk;
    logic rst;
    logic err_clr;
    logic error_led;

    bcd_req_if  #(.M(M))                  req0_if ();
    bcd_req_if  #(.M(M))                  req1_if ();
    bcd_conv_if #(.M(M), .BCD_WIDTH(BW))  conv_if ();
    bcd_out_if  #(.BCD_WIDTH(BW))         out_if ();

    bcd_conv_ctrl #(.M(M), .BCD_WIDTH(BW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0_if),
        .req1      (req1_if),
        .conv      (conv_if),
        .out       (out_if),
        .err_clr   (err_clr),
        .error_led (error_led)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    job_t issue_q[$];
    res_t exp_q[$];
    bit   last_grant = 1'b1;
    int   force_latency = 0;
    bit   hold_ready_low = 1'b0;
    bit   pending_timeout = 1'b0;
    int   to_ce_cycle = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference conversion: decimal digits of the magnitude in the low 13
    // nibbles, 0xA marker for fixed-point, 0xB sign nibble for negatives.
    function automatic logic [59:0] ref_bcd(input logic [23:0] v, input bit fx, input bit sg);
        int unsigned mag;
        bit          neg;
        logic [59:0] r;
        neg = sg && v[23];
        mag = neg ? (32'd16777216 - {8'd0, v}) : {8'd0, v};
        r = '0;
        for (int i = 0; i < 13; i++) begin
            r[i*4 +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        r[55:52] = fx ? 4'hA : 4'h0;
        r[59:56] = neg ? 4'hB : 4'h0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Presents one or two requests and waits until each has been accepted.
    // Must be called just after a rising edge so no accept goes unseen.
    task automatic applyStimulus(input bit en0, input bit en1,
                                 input logic [23:0] v0, input bit f0, input bit s0,
                                 input logic [23:0] v1, input bit f1, input bit s1);
        bit   p0, p1, r0, r1, g;
        int   budget;
        job_t j;
        p0 = en0;
        p1 = en1;
        if (en0) begin
            req0_if.valid = 1'b1; req0_if.val = v0; req0_if.fixed = f0; req0_if.is_signed = s0;
        end
        if (en1) begin
            req1_if.valid = 1'b1; req1_if.val = v1; req1_if.fixed = f1; req1_if.is_signed = s1;
        end
        budget = 0;
        while ((p0 || p1) && budget < 3000) begin
            @(negedge clk);
            budget++;
            r0 = req0_if.ready;
            r1 = req1_if.ready;
            if (r0 || r1) begin
                checkOutput("ready_onehot", 64'(r0 & r1), 64'd0);
                g = r1;
                if (p0 && p1) checkOutput("rr_grant", 64'(g), 64'(!last_grant));
                else          checkOutput("grant_sole", 64'(g), 64'(p1));
                j.src = g;
                j.val = g ? v1 : v0;
                j.fx  = g ? f1 : f0;
                j.sg  = g ? s1 : s0;
                issue_q.push_back(j);
                last_grant = g;
                @(posedge clk);
                #1;
                if (g) begin p1 = 1'b0; req1_if.valid = 1'b0; end
                else   begin p0 = 1'b0; req0_if.valid = 1'b0; end
            end
        end
        if (p0 || p1) begin
            checkOutput("accept_timeout", 64'd1, 64'd0);
            req0_if.valid = 1'b0;
            req1_if.valid = 1'b0;
        end
    endtask

    // Waits until every issued job has been delivered and consumed.
    task automatic drain();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while ((exp_q.size() != 0 || issue_q.size() != 0 || out_if.valid) && budget < 2000);
        if (budget >= 2000) checkOutput("drain_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        issue_q.delete();
        exp_q.delete();
        pending_timeout = 1'b0;
        last_grant = 1'b1;
    endtask

    // Display driver: random back-pressure unless forced low.
    initial begin
        out_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_if.ready = hold_ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Converter model: starts on conv_ce, raises done after the chosen
    // latency, forgets everything on conv_rst. Latency above TO never lands.
    initial begin
        bit   busy;
        int   ce_cyc, job_lat, lat;
        job_t it;
        res_t r;
        busy = 1'b0; ce_cyc = 0; job_lat = 0;
        conv_if.done = 1'b0;
        conv_if.bcd  = '0;
        forever begin
            @(negedge clk);
            if (conv_if.rst) begin
                busy = 1'b0;
                conv_if.done = 1'b0;
            end else if (conv_if.ce) begin
                if (issue_q.size() == 0) begin
                    checkOutput("ce_without_accept", 64'd1, 64'd0);
                end else begin
                    it = issue_q.pop_front();
                    checkOutput("conv_val", 64'(conv_if.val), 64'(it.val));
                    checkOutput("conv_fixed", 64'(conv_if.fixed), 64'(it.fx));
                    checkOutput("conv_signed", 64'(conv_if.is_signed), 64'(it.sg));
                    checkOutput("src_at_issue", 64'(out_if.src), 64'(it.src));
                    lat = (force_latency != 0) ? force_latency : $urandom_range(1, 40);
                    busy = 1'b1;
                    ce_cyc = cyc;
                    job_lat = lat;
                    if (lat <= TO) begin
                        r.bcd = ref_bcd(it.val, it.fx, it.sg);
                        r.src = it.src;
                        exp_q.push_back(r);
                    end else begin
                        pending_timeout = 1'b1;
                        to_ce_cycle = cyc;
                    end
                end
            end
            if (busy && !conv_if.done && (cyc - ce_cyc) >= job_lat) begin
                conv_if.done = 1'b1;
                conv_if.bcd  = ref_bcd(conv_if.val, conv_if.fixed, conv_if.is_signed);
            end
        end
    end

    // Monitor: scoreboard pops on consumption, plus handshake timing rules.
    initial begin
        bit          prev_valid, prev_rst, prev_ce, prev_err, prev_consumed, prev_src;
        logic [59:0] prev_bcd;
        res_t        r;
        prev_valid = 0; prev_rst = 0; prev_ce = 0; prev_err = 0; prev_consumed = 0;
        prev_src = 0; prev_bcd = '0;
        forever begin
            @(negedge clk);
            if (prev_consumed) checkOutput("valid_drop", 64'(out_if.valid), 64'd0);
            if (out_if.valid) begin
                if (!prev_valid) begin
                    checkOutput("conv_rst_before_valid", 64'(prev_rst), 64'd1);
                    checkOutput("valid_expected", 64'(exp_q.size() != 0), 64'd1);
                end else if (!prev_consumed) begin
                    checkOutput("hold_bcd_stable", 64'(out_if.bcd), 64'(prev_bcd));
                    checkOutput("hold_src_stable", 64'(out_if.src), 64'(prev_src));
                end
                if (out_if.ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        r = exp_q.pop_front();
                        checkOutput("out_bcd", 64'(out_if.bcd), 64'(r.bcd));
                        checkOutput("out_src", 64'(out_if.src), 64'(r.src));
                    end
                end
            end
            if (conv_if.ce) begin
                checkOutput("ce_single_pulse", 64'(prev_ce), 64'd0);
                checkOutput("ce_not_in_hold", 64'(out_if.valid), 64'd0);
            end
            if (error_led && !prev_err) begin
                checkOutput("timeout_expected", 64'(pending_timeout), 64'd1);
                // Set on the TO-th rising edge after the edge that takes conv_ce.
                if (pending_timeout) checkOutput("timeout_cycle", 64'(cyc - to_ce_cycle), 64'(TO + 1));
                pending_timeout = 1'b0;
            end
            prev_consumed = out_if.valid && out_if.ready;
            prev_valid    = out_if.valid;
            prev_bcd      = out_if.bcd;
            prev_src      = out_if.src;
            prev_rst      = conv_if.rst;
            prev_ce       = conv_if.ce;
            prev_err      = error_led;
        end
    end

    initial begin
        int budget;
        bit e0, e1;
        rst = 1'b1;
        err_clr = 1'b0;
        req0_if.valid = 0; req0_if.val = '0; req0_if.fixed = 0; req0_if.is_signed = 0;
        req1_if.valid = 0; req1_if.val = '0; req1_if.fixed = 0; req1_if.is_signed = 0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_conv_rst", 64'(conv_if.rst), 64'd1);
        checkOutput("rst_out_valid", 64'(out_if.valid), 64'd0);
        checkOutput("rst_conv_ce", 64'(conv_if.ce), 64'd0);
        checkOutput("rst_error_led", 64'(error_led), 64'd0);
        checkOutput("rst_out_bcd", 64'(out_if.bcd), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single req0, fixed latency 30
        $display("[TB] test 1: single ALU request");
        force_latency = 30;
        applyStimulus(1, 0, 24'd123456, 0, 0, 24'd0, 0, 0);
        drain();

        // 2: ties after reset alternate 0,1,0,1...
        $display("[TB] test 2: round-robin ties");
        @(posedge clk); #1; rst = 1'b1; flush_model();
        @(posedge clk); #1; rst = 1'b0;
        force_latency = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 24'($urandom), 1'($urandom), 1'($urandom),
                                24'($urandom), 1'($urandom), 1'($urandom));
            drain();
        end

        // 3: held result with back-pressure, pending req0 must wait
        $display("[TB] test 3: back-pressure hold");
        hold_ready_low = 1'b1;
        force_latency = 12;
        applyStimulus(0, 1, 24'd0, 0, 0, 24'hFFFF80, 0, 1);
        req0_if.valid = 1'b1; req0_if.val = 24'd999; req0_if.fixed = 1'b1; req0_if.is_signed = 1'b0;
        budget = 0;
        while (!out_if.valid && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("hold_reached", 64'(out_if.valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_valid", 64'(out_if.valid), 64'd1);
            checkOutput("no_grant_in_hold", 64'(req0_if.ready), 64'd0);
            checkOutput("no_ce_in_hold", 64'(conv_if.ce), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        hold_ready_low = 1'b0;
        applyStimulus(1, 0, 24'd999, 1, 0, 24'd0, 0, 0);
        drain();

        // 4: converter never finishes
        $display("[TB] test 4: conversion timeout");
        force_latency = 1000;
        applyStimulus(1, 0, 24'd55555, 0, 0, 24'd0, 0, 0);
        budget = 0;
        while (!error_led && budget < TO + 50) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("error_set", 64'(error_led), 64'd1);
        repeat (5) @(negedge clk);
        checkOutput("error_sticky", 64'(error_led), 64'd1);
        checkOutput("no_valid_after_timeout", 64'(out_if.valid), 64'd0);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err_clr", 64'(error_led), 64'd0);
        @(posedge clk); #1;

        // 5: done on the last allowed wait cycle wins over timeout
        $display("[TB] test 5: done coincides with timeout");
        force_latency = TO;
        applyStimulus(0, 1, 24'd0, 0, 0, 24'd8765432, 1, 0);
        drain();
        checkOutput("no_err_coincide", 64'(error_led), 64'd0);

        // 6: async reset during WAIT, then a pending req0 goes through
        $display("[TB] test 6: reset during conversion");
        force_latency = 50;
        applyStimulus(1, 0, 24'd777777, 1, 1, 24'd0, 0, 0);
        repeat (10) @(posedge clk);
        #3;
        req0_if.valid = 1'b1; req0_if.val = 24'd4242; req0_if.fixed = 1'b0; req0_if.is_signed = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("arst_conv_rst", 64'(conv_if.rst), 64'd1);
        checkOutput("arst_conv_ce", 64'(conv_if.ce), 64'd0);
        checkOutput("arst_conv_val", 64'(conv_if.val), 64'd0);
        checkOutput("arst_conv_fixed", 64'(conv_if.fixed), 64'd0);
        checkOutput("arst_conv_signed", 64'(conv_if.is_signed), 64'd0);
        checkOutput("arst_out_bcd", 64'(out_if.bcd), 64'd0);
        checkOutput("arst_out_src", 64'(out_if.src), 64'd0);
        checkOutput("arst_out_valid", 64'(out_if.valid), 64'd0);
        checkOutput("arst_req0_ready", 64'(req0_if.ready), 64'd0);
        flush_model();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        force_latency = 20;
        applyStimulus(1, 0, 24'd4242, 0, 0, 24'd0, 0, 0);
        drain();

        // Random traffic with random latency and back-pressure
        $display("[TB] random traffic");
        for (int k = 0; k < 30; k++) begin
            force_latency = ($urandom_range(0, 9) == 0) ? TO : 0;
            e0 = 1'($urandom);
            e1 = 1'($urandom);
            if (!e0 && !e1) e0 = 1'b1;
            applyStimulus(e0, e1, 24'($urandom), 1'($urandom), 1'($urandom),
                                  24'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();
        checkOutput("final_no_error", 64'(error_led), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
